// File: rtl/acondicionador_botones_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acondicionador_botones_pkg
// Description : Shared debounce state encoding, channel map and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package acondicionador_botones_pkg;

    typedef enum logic [1:0] {
        REPOSO        = 2'd0,
        CONFIRMA_ALTO = 2'd1,
        ALTO          = 2'd2,
        CONFIRMA_BAJO = 2'd3
    } estado_t;

    localparam int unsigned C_DEBOUNCE_CYC_DEF = 1_000_000;
    localparam int unsigned C_LONG_CYC_DEF     = 250_000_000;

    localparam int C_NUM_CANALES = 5;
    localparam int C_CH_TEST     = 0;
    localparam int C_CH_ENERGIA  = 1;
    localparam int C_CH_MEDICINA = 2;
    localparam int C_CH_DESCANSO = 3;
    localparam int C_CH_ANIMO    = 4;

endpackage : acondicionador_botones_pkg
`default_nettype wire

// File: rtl/acondicionador_botones_if.sv
`default_nettype none
// ============================================================================
// Module      : acondicionador_botones_if
// Description : Raw board inputs and conditioned outputs toward Modos.
// Revision    : 1.0 - initial release
// ============================================================================
interface acondicionador_botones_if;
    logic Raw_Test;
    logic Raw_Energia;
    logic Raw_Medicina;
    logic Raw_Descanso;
    logic Raw_Animo;
    logic B_Test;
    logic B_Energia;
    logic B_Medicina;
    logic Entrada_Descanso;
    logic Entrada_Animo;

    modport master (
        output Raw_Test, Raw_Energia, Raw_Medicina, Raw_Descanso, Raw_Animo,
        input  B_Test, B_Energia, B_Medicina, Entrada_Descanso, Entrada_Animo
    );

    modport slave (
        input  Raw_Test, Raw_Energia, Raw_Medicina, Raw_Descanso, Raw_Animo,
        output B_Test, B_Energia, B_Medicina, Entrada_Descanso, Entrada_Animo
    );
endinterface : acondicionador_botones_if
`default_nettype wire

// File: rtl/acondicionador_botones_antirrebote.sv
`default_nettype none
// ============================================================================
// Module      : acondicionador_botones_antirrebote
// Description : 2-FF synchroniser plus debounce FSM; emits level and rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module acondicionador_botones_antirrebote
    import acondicionador_botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = C_DEBOUNCE_CYC_DEF
) (
    input  wire logic clk,
    input  wire logic B_Reset,
    input  wire logic i_raw,
    output logic      o_nivel,
    output logic      o_subida
);

    localparam int unsigned C_CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [C_CNT_W-1:0] C_DEB = C_CNT_W'(DEBOUNCE_CYC);
    localparam logic [C_CNT_W-1:0] C_UNO = C_CNT_W'(1);

    logic [1:0]         r_sync;
    estado_t            r_estado;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_nivel;
    logic               r_subida;
    logic               w_muestra;
    logic [C_CNT_W-1:0] w_cnt_sig;

    assign w_muestra = r_sync[1];

    // A confirmation run always starts at 1 when leaving a stable state.
    always_comb begin
        w_cnt_sig = r_cnt + C_UNO;
        if (r_estado == REPOSO || r_estado == ALTO) begin
            w_cnt_sig = C_UNO;
        end
    end

    always_ff @(posedge clk) begin
        if (!B_Reset) begin
            r_sync   <= 2'b00;
            r_estado <= REPOSO;
            r_cnt    <= '0;
            r_nivel  <= 1'b0;
            r_subida <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_raw};
            r_subida <= 1'b0;
            case (r_estado)
                REPOSO, CONFIRMA_ALTO: begin
                    if (!w_muestra) begin
                        r_estado <= REPOSO;
                        r_cnt    <= '0;
                    end else if (w_cnt_sig == C_DEB) begin
                        r_estado <= ALTO;
                        r_cnt    <= '0;
                        r_nivel  <= 1'b1;
                        r_subida <= 1'b1;
                    end else begin
                        r_estado <= CONFIRMA_ALTO;
                        r_cnt    <= w_cnt_sig;
                    end
                end
                ALTO, CONFIRMA_BAJO: begin
                    if (w_muestra) begin
                        r_estado <= ALTO;
                        r_cnt    <= '0;
                    end else if (w_cnt_sig == C_DEB) begin
                        r_estado <= REPOSO;
                        r_cnt    <= '0;
                        r_nivel  <= 1'b0;
                    end else begin
                        r_estado <= CONFIRMA_BAJO;
                        r_cnt    <= w_cnt_sig;
                    end
                end
                default: begin
                    r_estado <= REPOSO;
                    r_cnt    <= '0;
                    r_nivel  <= 1'b0;
                end
            endcase
        end
    end

    assign o_nivel  = r_nivel;
    assign o_subida = r_subida;

endmodule : acondicionador_botones_antirrebote
`default_nettype wire

// File: rtl/acondicionador_botones.sv
`default_nettype none
// ============================================================================
// Module      : acondicionador_botones
// Description : Conditions buttons/sensors; long-press toggles B_Test.
// Revision    : 1.0 - initial release
// ============================================================================
module acondicionador_botones
    import acondicionador_botones_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = C_DEBOUNCE_CYC_DEF,
    parameter int unsigned LONG_CYC     = C_LONG_CYC_DEF
) (
    input  wire logic               clk,
    input  wire logic               B_Reset,
    acondicionador_botones_if.slave bus
);

    localparam int unsigned C_HOLD_W = $clog2(LONG_CYC + 1);
    localparam logic [C_HOLD_W-1:0] C_LONG = C_HOLD_W'(LONG_CYC);
    localparam logic [C_HOLD_W-1:0] C_UNO  = C_HOLD_W'(1);

    logic [C_NUM_CANALES-1:0] w_raw;
    logic [C_NUM_CANALES-1:0] w_nivel;
    logic [C_NUM_CANALES-1:0] w_subida;
    logic [C_HOLD_W-1:0]      r_hold;
    logic                     r_b_test;
    logic                     w_unused;

    assign w_raw[C_CH_TEST]     = bus.Raw_Test;
    assign w_raw[C_CH_ENERGIA]  = bus.Raw_Energia;
    assign w_raw[C_CH_MEDICINA] = bus.Raw_Medicina;
    assign w_raw[C_CH_DESCANSO] = bus.Raw_Descanso;
    assign w_raw[C_CH_ANIMO]    = bus.Raw_Animo;

    for (genvar gi = 0; gi < C_NUM_CANALES; gi++) begin : g_canal
        acondicionador_botones_antirrebote #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_antirrebote (
            .clk      (clk),
            .B_Reset  (B_Reset),
            .i_raw    (w_raw[gi]),
            .o_nivel  (w_nivel[gi]),
            .o_subida (w_subida[gi])
        );
    end

    // Hold counter saturates, so the toggle fires once per long press.
    always_ff @(posedge clk) begin
        if (!B_Reset) begin
            r_hold   <= '0;
            r_b_test <= 1'b0;
        end else if (!w_nivel[C_CH_TEST]) begin
            r_hold <= '0;
        end else if (r_hold != C_LONG) begin
            r_hold <= r_hold + C_UNO;
            if (r_hold == C_LONG - C_UNO) begin
                r_b_test <= ~r_b_test;
            end
        end
    end

    assign bus.B_Test           = r_b_test;
    assign bus.B_Energia        = w_subida[C_CH_ENERGIA];
    assign bus.B_Medicina       = w_subida[C_CH_MEDICINA];
    assign bus.Entrada_Descanso = w_nivel[C_CH_DESCANSO];
    assign bus.Entrada_Animo    = w_nivel[C_CH_ANIMO];

    // Channel outputs that have no consumer at this level.
    assign w_unused = ^{w_subida[C_CH_TEST], w_subida[C_CH_DESCANSO],
                        w_subida[C_CH_ANIMO], w_nivel[C_CH_ENERGIA],
                        w_nivel[C_CH_MEDICINA]};

endmodule : acondicionador_botones
`default_nettype wire

// File: tb/tb_acondicionador_botones.sv
`default_nettype none
// ============================================================================
// Module      : tb_acondicionador_botones
// Description : Directed self-checking bench, DEBOUNCE_CYC=4, LONG_CYC=20.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acondicionador_botones;

    logic clk;
    logic B_Reset;
    int   checks;
    int   errors;

    // Per-window monitor state, edges numbered from the last clear_mon
    int   edge_cnt;
    int   e_cnt, e_first, m_cnt, m_first;
    int   d_cnt, d_first, d_last, a_cnt;
    int   t_toggles, t_edge;
    logic prev_btest;

    acondicionador_botones_if bus ();

    acondicionador_botones #(
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20)
    ) dut (
        .clk     (clk),
        .B_Reset (B_Reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_mon;
        edge_cnt = 0;
        e_cnt = 0; e_first = 0; m_cnt = 0; m_first = 0;
        d_cnt = 0; d_first = 0; d_last = 0; a_cnt = 0;
        t_toggles = 0; t_edge = 0;
        prev_btest = bus.B_Test;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        edge_cnt++;
        if (bus.B_Energia === 1'b1) begin
            e_cnt++;
            if (e_first == 0) e_first = edge_cnt;
        end
        if (bus.B_Medicina === 1'b1) begin
            m_cnt++;
            if (m_first == 0) m_first = edge_cnt;
        end
        if (bus.Entrada_Descanso === 1'b1) begin
            d_cnt++;
            if (d_first == 0) d_first = edge_cnt;
            d_last = edge_cnt;
        end
        if (bus.Entrada_Animo === 1'b1) a_cnt++;
        if (bus.B_Test !== prev_btest) begin
            t_toggles++;
            t_edge = edge_cnt;
            prev_btest = bus.B_Test;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [4:0] salidas();
        return {bus.B_Test, bus.B_Energia, bus.B_Medicina,
                bus.Entrada_Descanso, bus.Entrada_Animo};
    endfunction

    task automatic test_reset;
        B_Reset = 1'b0;
        bus.Raw_Test = 1'b1; bus.Raw_Energia = 1'b1; bus.Raw_Medicina = 1'b1;
        bus.Raw_Descanso = 1'b1; bus.Raw_Animo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (salidas() !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d got %b want 00000", i, salidas());
            end
        end
        clear_mon();
        B_Reset = 1'b1;
        ticks(12);
        checks++;
        if (e_cnt !== 1 || e_first !== 6) begin
            errors++;
            $display("FAIL reset_energia_pulse got count %0d edge %0d want 1 at 6", e_cnt, e_first);
        end
        checks++;
        if (m_cnt !== 1 || m_first !== 6) begin
            errors++;
            $display("FAIL reset_medicina_pulse got count %0d edge %0d want 1 at 6", m_cnt, m_first);
        end
        checks++;
        if (d_first !== 6) begin
            errors++;
            $display("FAIL reset_descanso_rise got edge %0d want 6", d_first);
        end
        bus.Raw_Test = 1'b0; bus.Raw_Energia = 1'b0; bus.Raw_Medicina = 1'b0;
        bus.Raw_Descanso = 1'b0; bus.Raw_Animo = 1'b0;
        ticks(10);
        checks++;
        if (salidas() !== 5'b0 || t_toggles !== 0) begin
            errors++;
            $display("FAIL reset_settle got %b toggles %0d want 00000 toggles 0", salidas(), t_toggles);
        end
    endtask

    task automatic test_bounce;
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            bus.Raw_Energia = 1'b1; ticks(2);
            bus.Raw_Energia = 1'b0; ticks(2);
        end
        checks++;
        if (e_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_quiet got %0d pulses want 0", e_cnt);
        end
        clear_mon();
        bus.Raw_Energia = 1'b1;
        ticks(10);
        checks++;
        if (e_cnt !== 1 || e_first !== 6) begin
            errors++;
            $display("FAIL bounce_pulse got count %0d edge %0d want 1 at 6", e_cnt, e_first);
        end
        bus.Raw_Energia = 1'b0;
        ticks(8);
    endtask

    task automatic test_short_long;
        clear_mon();
        bus.Raw_Test = 1'b1; ticks(10);
        bus.Raw_Test = 1'b0; ticks(12);
        checks++;
        if (bus.B_Test !== 1'b0 || t_toggles !== 0) begin
            errors++;
            $display("FAIL short_press got b_test %b toggles %0d want 0 and 0", bus.B_Test, t_toggles);
        end
        clear_mon();
        bus.Raw_Test = 1'b1; ticks(40);
        checks++;
        if (bus.B_Test !== 1'b1 || t_toggles !== 1 || t_edge !== 26) begin
            errors++;
            $display("FAIL long_press_1 got b_test %b toggles %0d edge %0d want 1, 1, 26",
                     bus.B_Test, t_toggles, t_edge);
        end
        bus.Raw_Test = 1'b0; ticks(8);
        bus.Raw_Test = 1'b1; ticks(30);
        checks++;
        if (bus.B_Test !== 1'b0 || t_toggles !== 2 || t_edge !== 74) begin
            errors++;
            $display("FAIL long_press_2 got b_test %b toggles %0d edge %0d want 0, 2, 74",
                     bus.B_Test, t_toggles, t_edge);
        end
        bus.Raw_Test = 1'b0; ticks(8);
    endtask

    task automatic test_sensors;
        clear_mon();
        bus.Raw_Descanso = 1'b1; ticks(3);
        bus.Raw_Descanso = 1'b0; ticks(8);
        checks++;
        if (d_cnt !== 0) begin
            errors++;
            $display("FAIL sensor_glitch got %0d high cycles want 0", d_cnt);
        end
        clear_mon();
        bus.Raw_Descanso = 1'b1; ticks(10);
        bus.Raw_Descanso = 1'b0; ticks(10);
        checks++;
        if (d_first !== 6 || d_last !== 15 || d_cnt !== 10) begin
            errors++;
            $display("FAIL sensor_level got first %0d last %0d count %0d want 6, 15, 10",
                     d_first, d_last, d_cnt);
        end
        checks++;
        if (a_cnt !== 0) begin
            errors++;
            $display("FAIL sensor_independent got animo high %0d cycles want 0", a_cnt);
        end
    endtask

    task automatic test_simultaneous;
        clear_mon();
        bus.Raw_Energia = 1'b1; bus.Raw_Medicina = 1'b1;
        ticks(10);
        checks++;
        if (e_cnt !== 1 || m_cnt !== 1) begin
            errors++;
            $display("FAIL simul_width got energia %0d medicina %0d want 1 and 1", e_cnt, m_cnt);
        end
        checks++;
        if (e_first !== 6 || m_first !== 6) begin
            errors++;
            $display("FAIL simul_edge got energia %0d medicina %0d want 6 and 6", e_first, m_first);
        end
        bus.Raw_Energia = 1'b0; bus.Raw_Medicina = 1'b0;
        ticks(8);
    endtask

    task automatic test_reset_mid;
        clear_mon();
        bus.Raw_Test = 1'b1;
        ticks(21);
        checks++;
        if (t_toggles !== 0) begin
            errors++;
            $display("FAIL mid_before_reset got %0d toggles want 0", t_toggles);
        end
        B_Reset = 1'b0;
        ticks(3);
        checks++;
        if (salidas() !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 00000", salidas());
        end
        clear_mon();
        B_Reset = 1'b1;
        ticks(30);
        checks++;
        if (bus.B_Test !== 1'b1 || t_toggles !== 1 || t_edge !== 26) begin
            errors++;
            $display("FAIL mid_requalify got b_test %b toggles %0d edge %0d want 1, 1, 26",
                     bus.B_Test, t_toggles, t_edge);
        end
        bus.Raw_Test = 1'b0;
        ticks(8);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        B_Reset = 1'b0;
        bus.Raw_Test = 1'b0; bus.Raw_Energia = 1'b0; bus.Raw_Medicina = 1'b0;
        bus.Raw_Descanso = 1'b0; bus.Raw_Animo = 1'b0;
        clear_mon();
        test_reset();
        test_bounce();
        test_short_long();
        test_sensors();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_acondicionador_botones
`default_nettype wire
